// File: rtl/board_io_pkg.sv
// Shared sizes and auto-repeat state encoding for the board-input front end.
package board_io_pkg;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned NUM_SW   = 10;

  typedef logic [1:0] rep_state_t;

  localparam rep_state_t IDLE   = 2'd0;
  localparam rep_state_t DELAY  = 2'd1;
  localparam rep_state_t REPEAT = 2'd2;

endpackage

// File: rtl/debounce_bit.sv
// One asynchronous input bit: synchronizer chain, stability debouncer, registered
// transition pulse, plus a look-ahead flip strobe for downstream state machines.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        SYNC_RST_VAL    = 1'b0,
  parameter logic        INVERT          = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o,
  output logic flip_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   sync_val;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    sync_val = sync_q[SYNC_STAGES-1] ^ INVERT;
    cnt_inc  = cnt_q + 1'b1;
    cnt_d    = '0;
    level_d  = level_q;
    pulse_d  = 1'b0;
    // Counting only while the settled input disagrees with the level; any agreement restarts it.
    if (sync_val != level_q) begin
      if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
        level_d = ~level_q;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q  <= {SYNC_STAGES{SYNC_RST_VAL}};
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign flip_o  = pulse_d;

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: debounced keys/switches, edge pulses and per-key
// auto-repeat strobes, all registered.
module input_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] KEY_N,
  input  logic [NUM_SW-1:0]   SW_RAW,
  output logic [NUM_KEYS-1:0] KEY_LEVEL,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE,
  output logic [NUM_KEYS-1:0] KEY_REPEAT,
  output logic [NUM_SW-1:0]   SW_LEVEL,
  output logic [NUM_SW-1:0]   SW_CHANGE
);

  localparam int unsigned DW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned PW = $clog2(REPEAT_PERIOD + 1);

  logic [NUM_KEYS-1:0] key_flip;
  logic [NUM_KEYS-1:0] key_pulse_unused;
  logic [NUM_SW-1:0]   sw_flip_unused;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic [1:0]    state_q, state_d;
      logic [DW-1:0] dly_q, dly_d;
      logic [PW-1:0] per_q, per_d;
      logic          rep_q, rep_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;

      // Keys idle high at the pin, so the synchronizer resets to "released".
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES),
        .SYNC_RST_VAL   (1'b1),
        .INVERT         (1'b1)
      ) u_db (
        .clk    (CLK),
        .srst   (RST),
        .raw_i  (KEY_N[gi]),
        .level_o(KEY_LEVEL[gi]),
        .pulse_o(key_pulse_unused[gi]),
        .flip_o (key_flip[gi])
      );

      always_comb begin
        press_d = key_flip[gi] & ~KEY_LEVEL[gi];
        rel_d   = key_flip[gi] &  KEY_LEVEL[gi];
        state_d = state_q;
        dly_d   = '0;
        per_d   = '0;
        rep_d   = 1'b0;
        case (state_q)
          IDLE: begin
            if (press_d) begin
              state_d = DELAY;
              rep_d   = 1'b1;
            end
          end
          DELAY: begin
            if (rel_d) begin
              state_d = IDLE;
            end else if (dly_q + 1'b1 == DW'(REPEAT_DELAY)) begin
              state_d = REPEAT;
              rep_d   = 1'b1;
            end else begin
              dly_d = dly_q + 1'b1;
            end
          end
          REPEAT: begin
            if (rel_d) begin
              state_d = IDLE;
            end else if (per_q + 1'b1 == PW'(REPEAT_PERIOD)) begin
              rep_d = 1'b1;
            end else begin
              per_d = per_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          state_q <= IDLE;
          dly_q   <= '0;
          per_q   <= '0;
          rep_q   <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          dly_q   <= dly_d;
          per_q   <= per_d;
          rep_q   <= rep_d;
          press_q <= press_d;
          rel_q   <= rel_d;
        end
      end

      assign KEY_PRESS[gi]   = press_q;
      assign KEY_RELEASE[gi] = rel_q;
      assign KEY_REPEAT[gi]  = rep_q;
    end

    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES),
        .SYNC_RST_VAL   (1'b0),
        .INVERT         (1'b0)
      ) u_db (
        .clk    (CLK),
        .srst   (RST),
        .raw_i  (SW_RAW[gi]),
        .level_o(SW_LEVEL[gi]),
        .pulse_o(SW_CHANGE[gi]),
        .flip_o (sw_flip_unused[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Cycle-by-cycle vector table for input_conditioner; expectations are queued at
// drive time and popped when the outputs are sampled after the edge.
module tb_input_conditioner;

  localparam int NVEC = 211;
  localparam int F_KLEV = 0, F_KPRS = 1, F_KREL = 2, F_KREP = 3, F_SWLEV = 4, F_SWCHG = 5;

  typedef struct {
    logic       rst;
    logic [3:0] key_n;
    logic [9:0] sw;
    logic [3:0] klev, kprs, krel, krep;
    logic [9:0] swlev, swchg;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic [9:0] sw_raw;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic [9:0] sw_level, sw_change;

  vec_t vec [NVEC];
  vec_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .KEY_N      (key_n),
    .SW_RAW     (sw_raw),
    .KEY_LEVEL  (key_level),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release),
    .KEY_REPEAT (key_repeat),
    .SW_LEVEL   (sw_level),
    .SW_CHANGE  (sw_change)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic stim(input int from, input int to, input logic r,
                      input logic [3:0] kn, input logic [9:0] sw);
    for (int i = from; i <= to; i++) begin
      vec[i].rst   = r;
      vec[i].key_n = kn;
      vec[i].sw    = sw;
    end
  endtask

  task automatic expect_set(input int f, input int from, input int to, input logic [9:0] m);
    for (int i = from; i <= to; i++) begin
      case (f)
        F_KLEV:  vec[i].klev  = vec[i].klev  | m[3:0];
        F_KPRS:  vec[i].kprs  = vec[i].kprs  | m[3:0];
        F_KREL:  vec[i].krel  = vec[i].krel  | m[3:0];
        F_KREP:  vec[i].krep  = vec[i].krep  | m[3:0];
        F_SWLEV: vec[i].swlev = vec[i].swlev | m;
        default: vec[i].swchg = vec[i].swchg | m;
      endcase
    end
  endtask

  task automatic check(input string name, input int idx,
                       input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at vector %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t       e;
    logic [8:0] glitch;

    for (int i = 0; i < NVEC; i++) vec[i] = '{default: '0};

    // Stimulus timeline (index = edge number the vector is applied before).
    stim(0,   2,   1'b1, 4'hF, 10'h000);
    stim(3,   22,  1'b0, 4'hF, 10'h000);
    stim(23,  29,  1'b0, 4'hE, 10'h000);
    stim(30,  69,  1'b0, 4'hF, 10'h000);
    glitch = 9'b011101101;
    for (int k = 0; k < 9; k++) vec[40 + k].sw[3] = glitch[k];
    stim(49,  57,  1'b0, 4'hF, 10'h008);
    stim(70,  106, 1'b0, 4'hB, 10'h000);
    stim(107, 129, 1'b0, 4'hF, 10'h000);
    stim(130, 137, 1'b0, 4'h0, 10'h3FF);
    stim(138, 149, 1'b0, 4'hF, 10'h000);
    stim(150, 171, 1'b0, 4'hD, 10'h000);
    stim(172, 173, 1'b1, 4'hD, 10'h000);
    stim(174, 195, 1'b0, 4'hD, 10'h000);
    stim(196, 210, 1'b0, 4'hF, 10'h000);

    // Clean press/release of key 0; release lands while still in DELAY.
    expect_set(F_KLEV, 28, 34, 10'h1);
    expect_set(F_KPRS, 28, 28, 10'h1);
    expect_set(F_KREP, 28, 28, 10'h1);
    expect_set(F_KREL, 35, 35, 10'h1);
    // Switch 3: glitches of 1..3 cycles ignored, final rise then fall.
    expect_set(F_SWLEV, 54, 62, 10'h008);
    expect_set(F_SWCHG, 54, 54, 10'h008);
    expect_set(F_SWCHG, 63, 63, 10'h008);
    // Key 2 auto-repeat; release coincides with a would-be strobe at 112.
    expect_set(F_KLEV, 75, 111, 10'h4);
    expect_set(F_KPRS, 75, 75, 10'h4);
    expect_set(F_KREP, 75, 75, 10'h4);
    for (int t = 85; t <= 109; t += 3) expect_set(F_KREP, t, t, 10'h4);
    expect_set(F_KREL, 112, 112, 10'h4);
    // Everything at once.
    expect_set(F_KLEV, 135, 142, 10'hF);
    expect_set(F_KPRS, 135, 135, 10'hF);
    expect_set(F_KREP, 135, 135, 10'hF);
    expect_set(F_KREL, 143, 143, 10'hF);
    expect_set(F_SWLEV, 135, 142, 10'h3FF);
    expect_set(F_SWCHG, 135, 135, 10'h3FF);
    expect_set(F_SWCHG, 143, 143, 10'h3FF);
    // Key 1 repeating, reset at 172..173, fresh press after reset.
    expect_set(F_KLEV, 155, 171, 10'h2);
    expect_set(F_KPRS, 155, 155, 10'h2);
    expect_set(F_KREP, 155, 155, 10'h2);
    for (int t = 165; t <= 171; t += 3) expect_set(F_KREP, t, t, 10'h2);
    expect_set(F_KLEV, 179, 200, 10'h2);
    expect_set(F_KPRS, 179, 179, 10'h2);
    expect_set(F_KREP, 179, 179, 10'h2);
    for (int t = 189; t <= 198; t += 3) expect_set(F_KREP, t, t, 10'h2);
    expect_set(F_KREL, 201, 201, 10'h2);

    for (int i = 0; i < NVEC; i++) begin
      rst    = vec[i].rst;
      key_n  = vec[i].key_n;
      sw_raw = vec[i].sw;
      exp_q.push_back(vec[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      $display("vec %0d rst=%b key_n=%h sw=%h -> lvl=%h prs=%h rel=%h rep=%h swl=%h swc=%h",
               i, e.rst, e.key_n, e.sw, key_level, key_press, key_release, key_repeat,
               sw_level, sw_change);
      check("key_level",   i, {6'd0, key_level},   {6'd0, e.klev});
      check("key_press",   i, {6'd0, key_press},   {6'd0, e.kprs});
      check("key_release", i, {6'd0, key_release}, {6'd0, e.krel});
      check("key_repeat",  i, {6'd0, key_repeat},  {6'd0, e.krep});
      check("sw_level",    i, sw_level,            e.swlev);
      check("sw_change",   i, sw_change,           e.swchg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
